// File: rtl/dma_axi_arb_mux_pkg.sv
// rtl/dma_axi_arb_mux_pkg.sv - owner encoding and lane-slice helpers shared by the scratch-memory front end
package dma_axi_arb_mux_pkg;

  localparam logic OWN_DMA  = 1'b0;
  localparam logic OWN_AXI  = 1'b1;

  // Width of the AXI-priority streak counter; covers limits up to 15.
  localparam int   STREAK_W = 4;

  // Low bit of a lane's slice inside a flat per-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dma_axi_rtag_pipe.sv
// rtl/dma_axi_rtag_pipe.sv - read-return tag delay line of {valid, owner, lane mask}
module dma_axi_rtag_pipe #(
  parameter int DEPTH    = 2,
  parameter int NUMLANES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tag_valid,
  input  logic                tag_owner,
  input  logic [NUMLANES-1:0] tag_mask,
  output logic                ret_valid,
  output logic                ret_owner,
  output logic [NUMLANES-1:0] ret_mask
);

  localparam int TW = NUMLANES + 2;

  logic [TW-1:0] stage [DEPTH];

  // Shift the tag along so it lines up with the bank's read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {tag_valid, tag_owner, tag_mask};
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign {ret_valid, ret_owner, ret_mask} = stage[DEPTH-1];

endmodule

// File: rtl/dma_axi_arb_mux.sv
// rtl/dma_axi_arb_mux.sv - registered DMA/AXI arbiter and mux in front of the per-lane scratch banks
module dma_axi_arb_mux
  import dma_axi_arb_mux_pkg::*;
#(
  parameter int ADDRWIDTH    = 11,
  parameter int NUMLANES     = 8,
  parameter int WIDTH        = 16,
  parameter int READLAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUMLANES*ADDRWIDTH-1:0] dma_addr,
  input  logic [NUMLANES*WIDTH-1:0]     dma_data,
  input  logic [NUMLANES-1:0]           dma_rden,
  input  logic [NUMLANES-1:0]           dma_wren,
  output logic                          dma_stall,
  output logic [NUMLANES*WIDTH-1:0]     dma_out,
  output logic [NUMLANES-1:0]           dma_out_valid,
  input  logic [ADDRWIDTH-1:0]          axi_addr,
  input  logic [NUMLANES*WIDTH-1:0]     axi_data,
  input  logic                          axi_req_en,
  input  logic                          axi_req_type,
  output logic                          axi_req_ready,
  output logic [NUMLANES*WIDTH-1:0]     axi_read_data,
  output logic                          axi_read_valid,
  output logic [NUMLANES*ADDRWIDTH-1:0] mem_addr,
  output logic [NUMLANES*WIDTH-1:0]     mem_data,
  output logic [NUMLANES-1:0]           mem_rden,
  output logic [NUMLANES-1:0]           mem_wren,
  input  logic [NUMLANES*WIDTH-1:0]     mem_readdata
);

  logic                dma_pend;
  logic                axi_grant;
  logic                dma_grant;
  logic [STREAK_W-1:0] streak;
  logic [NUMLANES-1:0] dma_rd_eff;
  logic                tag_valid;
  logic                tag_owner;
  logic [NUMLANES-1:0] tag_mask;
  logic                ret_valid;
  logic                ret_owner;
  logic [NUMLANES-1:0] ret_mask;

  assign dma_pend      = |(dma_rden | dma_wren);
  assign axi_req_ready = !(dma_pend && (streak == STREAK_W'(STARVE_LIMIT)));
  assign axi_grant     = axi_req_en && axi_req_ready;
  assign dma_grant     = !axi_grant && dma_pend;
  assign dma_stall     = dma_pend && axi_grant;
  // A lane asking for both read and write performs only the write.
  assign dma_rd_eff    = dma_rden & ~dma_wren;

  // Count consecutive AXI wins while the DMA waits; saturate at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (!dma_pend || dma_grant) begin
      streak <= '0;
    end else if (axi_grant && (streak != STREAK_W'(STARVE_LIMIT))) begin
      streak <= streak + 1'b1;
    end
  end

  // Register the winning request onto the bank interface; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_rden <= '0;
      mem_wren <= '0;
    end else begin
      mem_rden <= '0;
      mem_wren <= '0;
      if (axi_grant) begin
        for (int i = 0; i < NUMLANES; i++)
          mem_addr[lane_lo(i, ADDRWIDTH) +: ADDRWIDTH] <= axi_addr + ADDRWIDTH'(i);
        mem_data <= axi_data;
        if (axi_req_type) mem_wren <= '1;
        else              mem_rden <= '1;
      end else if (dma_grant) begin
        mem_addr <= dma_addr;
        mem_data <= dma_data;
        mem_wren <= dma_wren;
        mem_rden <= dma_rd_eff;
      end
    end
  end

  // Describe which lanes of this issue will return read data, and to which master.
  always_comb begin
    tag_owner = OWN_DMA;
    tag_mask  = '0;
    if (axi_grant) begin
      tag_owner = OWN_AXI;
      tag_mask  = axi_req_type ? '0 : '1;
    end else if (dma_grant) begin
      tag_mask  = dma_rd_eff;
    end
  end

  assign tag_valid = |tag_mask;

  dma_axi_rtag_pipe #(
    .DEPTH    (READLAT + 1),
    .NUMLANES (NUMLANES)
  ) u_rtag_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_valid (tag_valid),
    .tag_owner (tag_owner),
    .tag_mask  (tag_mask),
    .ret_valid (ret_valid),
    .ret_owner (ret_owner),
    .ret_mask  (ret_mask)
  );

  // Capture returning bank data for its owner and pulse that owner's strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      axi_read_data  <= '0;
      axi_read_valid <= 1'b0;
      dma_out        <= '0;
      dma_out_valid  <= '0;
    end else begin
      axi_read_valid <= 1'b0;
      dma_out_valid  <= '0;
      if (ret_valid && (ret_owner == OWN_AXI)) begin
        axi_read_data  <= mem_readdata;
        axi_read_valid <= 1'b1;
      end else if (ret_valid) begin
        dma_out_valid <= ret_mask;
        for (int i = 0; i < NUMLANES; i++)
          if (ret_mask[i])
            dma_out[lane_lo(i, WIDTH) +: WIDTH] <= mem_readdata[lane_lo(i, WIDTH) +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dma_axi_arb_mux.sv
// tb/tb_dma_axi_arb_mux.sv - randomized bench with a cycle-indexed reference model for dma_axi_arb_mux
module tb_dma_axi_arb_mux;

  localparam int AW = 11, NL = 8, W = 16, RL = 1, SL = 4, MAXC = 4096;
  localparam int AV = NL * AW;
  localparam int DV = NL * W;

  logic          clk = 1'b0;
  logic          reset;
  logic [AV-1:0] dma_addr;
  logic [DV-1:0] dma_data;
  logic [NL-1:0] dma_rden, dma_wren;
  logic          dma_stall;
  logic [DV-1:0] dma_out;
  logic [NL-1:0] dma_out_valid;
  logic [AW-1:0] axi_addr;
  logic [DV-1:0] axi_data;
  logic          axi_req_en, axi_req_type, axi_req_ready;
  logic [DV-1:0] axi_read_data;
  logic          axi_read_valid;
  logic [AV-1:0] mem_addr;
  logic [DV-1:0] mem_data;
  logic [NL-1:0] mem_rden, mem_wren;
  logic [DV-1:0] mem_readdata;

  dma_axi_arb_mux #(
    .ADDRWIDTH(AW), .NUMLANES(NL), .WIDTH(W), .READLAT(RL), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_rden(dma_rden), .dma_wren(dma_wren),
    .dma_stall(dma_stall), .dma_out(dma_out), .dma_out_valid(dma_out_valid),
    .axi_addr(axi_addr), .axi_data(axi_data), .axi_req_en(axi_req_en),
    .axi_req_type(axi_req_type), .axi_req_ready(axi_req_ready),
    .axi_read_data(axi_read_data), .axi_read_valid(axi_read_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Expected values indexed by cycle number.
  logic [AV-1:0] e_addr [MAXC];
  logic [DV-1:0] e_data [MAXC];
  logic [NL-1:0] e_rden [MAXC];
  logic [NL-1:0] e_wren [MAXC];
  logic          e_ready[MAXC];
  logic          e_stall[MAXC];
  logic          e_clr  [MAXC];
  logic          e_known[MAXC];
  logic          r_axi  [MAXC];
  logic [NL-1:0] r_dma  [MAXC];
  logic [DV-1:0] rd_hist[MAXC];

  int            axi_run  = 0;
  logic [AV-1:0] cur_addr = '0;
  logic [DV-1:0] cur_data = '0;
  logic          m_stall  = 1'b0;
  logic [DV-1:0] h_axi    = '0;
  logic [DV-1:0] h_dma    = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply the arbitration and issue rules to the inputs of the current cycle.
  task automatic model_cycle();
    int   n;
    logic pend, rdy, ag, dg;
    logic [NL-1:0] rd, wr;
    n    = cyc;
    pend = (dma_rden != 0) || (dma_wren != 0);
    rdy  = !(pend && axi_run == SL);
    ag   = axi_req_en && rdy;
    dg   = !ag && pend;
    e_ready[n] = rdy;
    e_stall[n] = pend && ag;
    e_known[n] = 1'b1;
    m_stall    = pend && ag;
    rd = '0;
    wr = '0;
    if (reset) begin
      cur_addr = '0;
      cur_data = '0;
      axi_run  = 0;
      e_clr[n+1] = 1'b1;
      for (int k = n + 1; k < MAXC; k++) begin
        r_axi[k] = 1'b0;
        r_dma[k] = '0;
      end
    end else begin
      e_clr[n+1] = 1'b0;
      if (ag) begin
        for (int i = 0; i < NL; i++)
          cur_addr[i*AW +: AW] = AW'((int'(axi_addr) + i) % (1 << AW));
        cur_data = axi_data;
        if (axi_req_type) wr = '1;
        else begin
          rd = '1;
          r_axi[n+2+RL] = 1'b1;
        end
      end else if (dg) begin
        cur_addr = dma_addr;
        cur_data = dma_data;
        for (int i = 0; i < NL; i++) begin
          wr[i] = dma_wren[i];
          rd[i] = dma_rden[i] && !dma_wren[i];
        end
        r_dma[n+2+RL] = rd;
      end
      if (!pend) axi_run = 0;
      else if (ag) axi_run = (axi_run < SL) ? axi_run + 1 : SL;
      else axi_run = 0;
    end
    e_addr[n+1] = cur_addr;
    e_data[n+1] = cur_data;
    e_rden[n+1] = rd;
    e_wren[n+1] = wr;
  endtask

  // Present fresh bank read data, record the model, then advance one cycle.
  task automatic issue();
    mem_readdata = rnd128();
    rd_hist[cyc] = mem_readdata;
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    dma_rden     = '0;
    dma_wren     = '0;
    dma_addr     = AV'(rnd128());
    dma_data     = rnd128();
    axi_req_en   = 1'b0;
    axi_req_type = 1'b0;
    axi_addr     = AW'($urandom);
    axi_data     = rnd128();
  endtask

  // Every cycle: compare all DUT outputs with the model.
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c >= 1 && c < MAXC && e_known[c] && e_known[c-1]) begin
      chk("axi_req_ready", axi_req_ready, e_ready[c]);
      chk("dma_stall", dma_stall, e_stall[c]);
      chk("mem_addr", mem_addr, e_addr[c]);
      chk("mem_data", mem_data, e_data[c]);
      chk("mem_rden", mem_rden, e_rden[c]);
      chk("mem_wren", mem_wren, e_wren[c]);
      if (e_clr[c]) begin
        h_axi = '0;
        h_dma = '0;
      end else begin
        if (r_axi[c]) h_axi = rd_hist[c-1];
        for (int i = 0; i < NL; i++)
          if (r_dma[c][i]) h_dma[i*W +: W] = rd_hist[c-1][i*W +: W];
      end
      chk("axi_read_valid", axi_read_valid, r_axi[c] && !e_clr[c]);
      chk("axi_read_data", axi_read_data, h_axi);
      chk("dma_out_valid", dma_out_valid, e_clr[c] ? '0 : r_dma[c]);
      chk("dma_out", dma_out, h_dma);
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      e_known[k] = 1'b0;
      e_clr[k]   = 1'b0;
      r_axi[k]   = 1'b0;
      r_dma[k]   = '0;
      rd_hist[k] = '0;
    end
    set_idle();
    reset = 1'b1;
    issue();
    issue();
    reset = 1'b0;
    set_idle();
    issue();

    // AXI read at the top of the address space wraps per lane.
    set_idle(); axi_req_en = 1'b1; axi_addr = 11'h7FE; issue();
    chk("A_rden", mem_rden, 8'hFF);
    chk("A_addr0", mem_addr[0 +: AW], 11'h7FE);
    chk("A_addr1", mem_addr[AW +: AW], 11'h7FF);
    chk("A_addr2", mem_addr[2*AW +: AW], 11'h000);
    chk("A_addr7", mem_addr[7*AW +: AW], 11'h005);
    set_idle(); issue();
    set_idle(); issue();
    chk("A_axi_valid", axi_read_valid, 1'b1);
    chk("A_axi_data", axi_read_data, rd_hist[cyc-1]);
    chk("A_dma_valid", dma_out_valid, 8'h00);

    // DMA lanes 0 and 3 read.
    set_idle(); dma_rden = 8'h09;
    dma_addr[0 +: AW] = 11'h010; dma_addr[3*AW +: AW] = 11'h020;
    #1; chk("B_stall", dma_stall, 1'b0);
    issue();
    chk("B_rden", mem_rden, 8'h09);
    chk("B_addr0", mem_addr[0 +: AW], 11'h010);
    chk("B_addr3", mem_addr[3*AW +: AW], 11'h020);
    set_idle(); issue();
    set_idle(); issue();
    chk("B_dma_valid", dma_out_valid, 8'h09);
    chk("B_axi_valid", axi_read_valid, 1'b0);

    // Continuous AXI reads against a pending DMA: 4 AXI wins then one DMA win.
    set_idle(); issue();
    for (int k = 0; k < 10; k++) begin
      axi_req_en = 1'b1; axi_req_type = 1'b0; dma_rden = 8'h01; dma_wren = 8'h00;
      #1;
      chk("C_ready", axi_req_ready, (k % 5) != 4);
      chk("C_stall", dma_stall, (k % 5) != 4);
      issue();
    end
    for (int k = 0; k < 4; k++) begin set_idle(); issue(); end

    // Interleaved AXI read, DMA read, AXI write, DMA read.
    set_idle(); axi_req_en = 1'b1; issue();
    set_idle(); dma_rden = 8'h0F; issue();
    set_idle(); axi_req_en = 1'b1; axi_req_type = 1'b1; issue();
    chk("D_axi_valid", axi_read_valid, 1'b1);
    chk("D_dma_idle0", dma_out_valid, 8'h00);
    set_idle(); dma_rden = 8'hF0; issue();
    chk("D_dma_first", dma_out_valid, 8'h0F);
    chk("D_axi_idle1", axi_read_valid, 1'b0);
    set_idle(); issue();
    chk("D_write_axi", axi_read_valid, 1'b0);
    chk("D_write_dma", dma_out_valid, 8'h00);
    set_idle(); issue();
    chk("D_dma_second", dma_out_valid, 8'hF0);

    // Lane with both read and write issues the write only.
    set_idle(); dma_rden = 8'h04; dma_wren = 8'h04; issue();
    chk("E_wren", mem_wren, 8'h04);
    chk("E_rden", mem_rden, 8'h00);
    set_idle(); issue();
    set_idle(); issue();
    chk("E_dma_valid", dma_out_valid, 8'h00);

    // Reset right after an AXI read issue drops the return.
    set_idle(); axi_req_en = 1'b1; issue();
    set_idle(); reset = 1'b1; issue();
    reset = 1'b0;
    chk("F_rden", mem_rden, 8'h00);
    chk("F_wren", mem_wren, 8'h00);
    chk("F_addr", mem_addr, '0);
    chk("F_data", mem_data, '0);
    chk("F_axi_valid", axi_read_valid, 1'b0);
    chk("F_axi_data", axi_read_data, '0);
    chk("F_dma_valid", dma_out_valid, 8'h00);
    chk("F_dma_out", dma_out, '0);
    set_idle(); issue();
    chk("F_no_return", axi_read_valid, 1'b0);

    // Random traffic; a stalled DMA holds its request.
    for (int k = 0; k < 1200; k++) begin
      reset        = ($urandom_range(0, 99) == 0);
      axi_req_en   = ($urandom_range(0, 2) != 0);
      axi_req_type = 1'($urandom);
      axi_addr     = AW'($urandom);
      axi_data     = rnd128();
      if (!m_stall) begin
        dma_rden = ($urandom_range(0, 2) == 0) ? NL'($urandom) : '0;
        dma_wren = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
        dma_addr = AV'(rnd128());
        dma_data = rnd128();
      end
      issue();
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin set_idle(); issue(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_axi_arb_mux.md
Name: dma_axi_arb_mux

Overview:
- Registered, arbitrated two-master front end to the banked per-lane vector scratch memory. Masters: the per-lane DMA engine and the AXI slave port.
- Generalises the earlier combinational mux:
  - parametrised lane count;
  - valid/ready backpressure on both masters;
  - starvation-bounded AXI priority;
  - read-return routing to the issuing master via a latency-matched tag pipeline.
- Sits between the vector DMA and AXI slave interface, and the lane memory banks.

Parameters:
ADDRWIDTH, 11, per-lane word address width
NUMLANES, 8, number of lanes/banks (power of 2, 1..64)
WIDTH, 16, per-lane data width
READLAT, 1, memory read latency in cycles from registered mem_rden to valid mem_readdata (1..4)
STARVE_LIMIT, 4, max consecutive AXI grants while DMA is pending (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dma_addr  in  NUMLANES*ADDRWIDTH  per-lane DMA address
dma_data  in  NUMLANES*WIDTH  per-lane DMA write data
dma_rden  in  NUMLANES  per-lane DMA read enable
dma_wren  in  NUMLANES  per-lane DMA write enable
dma_stall  out  1  DMA request not accepted this cycle; hold inputs
dma_out  out  NUMLANES*WIDTH  captured DMA read data
dma_out_valid  out  NUMLANES  per-lane DMA read-return strobe
axi_addr  in  ADDRWIDTH  AXI base word address
axi_data  in  NUMLANES*WIDTH  AXI write data, lane i = slice i
axi_req_en  in  1  AXI request valid
axi_req_type  in  1  1=write, 0=read
axi_req_ready  out  1  AXI request accepted when en&ready
axi_read_data  out  NUMLANES*WIDTH  captured AXI read data
axi_read_valid  out  1  one-cycle AXI read-return strobe
mem_addr  out  NUMLANES*ADDRWIDTH  registered bank address
mem_data  out  NUMLANES*WIDTH  registered bank write data
mem_rden  out  NUMLANES  registered bank read enable
mem_wren  out  NUMLANES  registered bank write enable
mem_readdata  in  NUMLANES*WIDTH  bank read data

Behaviour:
- Reset: all outputs 0; streak counter 0; tag pipeline cleared. In-flight reads are dropped and produce no strobes.
- dma_pend = |(dma_rden|dma_wren).
- Arbitration (combinational from inputs and registered streak):
  - axi_req_ready = !(dma_pend && streak==STARVE_LIMIT).
  - AXI granted when axi_req_en && axi_req_ready.
  - Otherwise DMA granted if dma_pend.
- dma_stall = dma_pend && AXI granted.
- Streak:
  - +1 on an AXI grant while dma_pend.
  - Cleared on a DMA grant or when !dma_pend.
  - Saturates at STARVE_LIMIT.
- Issue, cycle t grant → mem_* valid at t+1 (1-cycle registered).
  - AXI request:
    - mem_addr lane i = (axi_addr + i) mod 2^ADDRWIDTH; wraps at top.
    - mem_data = axi_data.
    - All lanes get rden (read) or wren (write).
  - DMA request: mem_* = dma_* copied lane-wise.
  - No grant: mem_rden = mem_wren = 0; mem_addr/mem_data hold their previous values.
- A lane with both dma_rden and dma_wren issues the write only; its rden is masked.
- Tag pipeline (READLAT+1 stages):
  - Per issue it carries {owner, rden mask}; owner encoding AXI=1, DMA=0.
  - Mask is all-ones for an AXI read, zero for writes.
- Return at t+1+READLAT: mem_readdata is registered.
  - If tag owner is AXI with nonzero mask: axi_read_data is captured; axi_read_valid=1 at t+2+READLAT.
  - If tag owner is DMA: dma_out lanes with mask bit set are captured; dma_out_valid=mask at t+2+READLAT.
  - Captured data holds until the next capture; strobes are one cycle.
- Throughput: one request per cycle, back-to-back; mixed owners are returned in issue order.
- Simultaneous AXI write and DMA access to the same bank address: the order is the grant order. No forwarding.
- Reset asserted mid-stream: next cycle mem_* = 0 and no strobes. Requests are re-accepted the cycle after reset deasserts.

Decomposition:
- Shared header with the owner encoding constants (OWN_DMA=0, OWN_AXI=1) and lane-slice index macros, reused by the AXI slave and DMA blocks.
- One sub-module, dma_axi_rtag_pipe: parametrised-depth shift register of {valid, owner, NUMLANES mask}, with synchronous reset.

Test Plan:
- AXI read only, axi_addr=0x7FE, NUMLANES=8, READLAT=1:
  - mem_addr lanes = 0x7FE, 0x7FF, 0x000..0x005 (wrap); mem_rden=0xFF at t+1.
  - axi_read_valid at t+3 carrying mem_readdata; dma_out_valid=0.
- DMA lanes 0,3 read at addr 0x10 and 0x20:
  - mem_rden=0x09 at t+1; dma_out_valid=0x09 at t+3.
  - dma_stall=0 throughout; axi_read_valid stays 0.
- AXI read continuously + DMA pending, STARVE_LIMIT=4:
  - 4 AXI grants with dma_stall=1, then axi_req_ready=0 for 1 cycle and the DMA is granted.
  - Pattern repeats every 5 cycles.
- Interleaved AXI read, DMA read, AXI write, DMA read over 4 consecutive cycles:
  - Returns occur in order AXI, DMA, DMA, with correct owner strobes.
  - The write produces no strobe.
- DMA lane 2 with rden and wren both set: mem_wren=0x04, mem_rden=0x00, no dma_out_valid.
- Reset asserted one cycle after an AXI read issue: no axi_read_valid ever; all outputs 0 the cycle after reset.
